// File: rtl/fwd_tag_pipe_pkg.sv
// Shared types and widths for the RAW forwarding tag pipeline.
// A tag records one in-flight destination register write.
package fwd_tag_pipe_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned CNT_W  = 32;

  localparam logic [REG_AW-1:0] X0 = '0;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              is_load;
  } tag_t;

  // Source operand reads a register that a live tag is about to write.
  function automatic logic src_hit(logic used, logic [REG_AW-1:0] rs, tag_t t);
    return used & t.valid & (rs == t.rd);
  endfunction

endpackage

// File: rtl/fwd_tag_pipe_if.sv
// Decode-side inputs and forwarding-mux outputs of the tag pipeline.
interface fwd_tag_pipe_if;
  import fwd_tag_pipe_pkg::*;

  logic              dec_valid;
  logic [REG_AW-1:0] dec_rd_sel;
  logic              dec_rd_we;
  logic              dec_is_load;
  logic [REG_AW-1:0] dec_rs1_sel;
  logic [REG_AW-1:0] dec_rs2_sel;
  logic              dec_rs1_used;
  logic              dec_rs2_used;
  logic              flush;
  logic              pipe_hold;
  logic [XLEN-1:0]   ex_alu_val;
  logic [XLEN-1:0]   mem_alu_val;
  logic [XLEN-1:0]   mem_load_val;
  logic [XLEN-1:0]   wb_val;

  logic [REG_AW-1:0] EX_raw_sel;
  logic [REG_AW-1:0] MEM_raw_sel;
  logic [REG_AW-1:0] WB_raw_sel;
  logic [XLEN-1:0]   EX_raw_val;
  logic [XLEN-1:0]   MEM_raw_val;
  logic [XLEN-1:0]   WB_raw_val;
  logic              dec_stall;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output dec_valid, dec_rd_sel, dec_rd_we, dec_is_load,
           dec_rs1_sel, dec_rs2_sel, dec_rs1_used, dec_rs2_used,
           flush, pipe_hold, ex_alu_val, mem_alu_val, mem_load_val, wb_val,
    input  EX_raw_sel, MEM_raw_sel, WB_raw_sel,
           EX_raw_val, MEM_raw_val, WB_raw_val, dec_stall, stall_cnt
  );

  modport slave (
    input  dec_valid, dec_rd_sel, dec_rd_we, dec_is_load,
           dec_rs1_sel, dec_rs2_sel, dec_rs1_used, dec_rs2_used,
           flush, pipe_hold, ex_alu_val, mem_alu_val, mem_load_val, wb_val,
    output EX_raw_sel, MEM_raw_sel, WB_raw_sel,
           EX_raw_val, MEM_raw_val, WB_raw_val, dec_stall, stall_cnt
  );

endinterface

// File: rtl/fwd_tag_stage.sv
// One pipeline tag register: freezes on hold, loads an empty tag on bubble.
module fwd_tag_stage
  import fwd_tag_pipe_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic hold,
  input  logic bubble,
  input  tag_t d,
  output tag_t q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (!hold) begin
      q <= bubble ? tag_t'('0) : d;
    end
  end

endmodule

// File: rtl/fwd_tag_pipe.sv
// Tracks rd tags through EX/MEM/WB, drives forwarding sel/val bundles and
// raises a one-cycle decode stall on load-use hazards.
module fwd_tag_pipe
  import fwd_tag_pipe_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  fwd_tag_pipe_if.slave  bus
);

  tag_t             dec_tag;
  tag_t             ex_tag;
  tag_t             mem_tag;
  tag_t             wb_tag;
  logic             stall;
  logic             ex_bubble;
  logic [CNT_W-1:0] cnt_q;

  // Only instructions that really write a non-x0 register become valid tags.
  always_comb begin
    dec_tag         = '0;
    dec_tag.valid   = bus.dec_valid & bus.dec_rd_we & (bus.dec_rd_sel != X0);
    dec_tag.rd      = bus.dec_rd_sel;
    dec_tag.is_load = bus.dec_is_load;
  end

  // EX tags are never x0, so a load-use match can never fire on x0.
  always_comb begin
    stall = bus.dec_valid & ex_tag.valid & ex_tag.is_load
          & (src_hit(bus.dec_rs1_used, bus.dec_rs1_sel, ex_tag)
           | src_hit(bus.dec_rs2_used, bus.dec_rs2_sel, ex_tag))
          & ~bus.flush;
    ex_bubble = stall | bus.flush;
  end

  fwd_tag_stage u_ex (
    .clk(clk), .rst(rst), .hold(bus.pipe_hold), .bubble(ex_bubble),
    .d(dec_tag), .q(ex_tag)
  );

  fwd_tag_stage u_mem (
    .clk(clk), .rst(rst), .hold(bus.pipe_hold), .bubble(1'b0),
    .d(ex_tag), .q(mem_tag)
  );

  fwd_tag_stage u_wb (
    .clk(clk), .rst(rst), .hold(bus.pipe_hold), .bubble(1'b0),
    .d(mem_tag), .q(wb_tag)
  );

  // Saturating count of stall cycles that actually took effect.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (stall && !bus.pipe_hold && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Dead stages present sel=0/val=0 so x0 reads through the mux give zero.
  always_comb begin
    bus.EX_raw_sel  = '0;
    bus.EX_raw_val  = '0;
    bus.MEM_raw_sel = '0;
    bus.MEM_raw_val = '0;
    bus.WB_raw_sel  = '0;
    bus.WB_raw_val  = '0;
    if (ex_tag.valid) begin
      bus.EX_raw_sel = ex_tag.rd;
      bus.EX_raw_val = ex_tag.is_load ? '0 : bus.ex_alu_val;
    end
    if (mem_tag.valid) begin
      bus.MEM_raw_sel = mem_tag.rd;
      bus.MEM_raw_val = mem_tag.is_load ? bus.mem_load_val : bus.mem_alu_val;
    end
    if (wb_tag.valid) begin
      bus.WB_raw_sel = wb_tag.rd;
      bus.WB_raw_val = bus.wb_val;
    end
  end

  assign bus.dec_stall = stall;
  assign bus.stall_cnt = cnt_q;

endmodule

// File: doc/fwd_tag_pipe.md
Name: fwd_tag_pipe

Overview:
- Producer side of the RAW forwarding interface.
- Tracks destination-register tags of in-flight instructions through the EX, MEM and WB stages and drives the EX/MEM/WB sel/val bundles that the forwarding mux consumes.
- Detects load-use hazards and issues a one-cycle decode stall with bubble insertion.
- Sits between the decoder/control path and the forwarding mux in the 5-stage RISC-V pipeline.

Parameters:
- XLEN, 32, datapath width
- REG_AW, 5, register-select width
- CNT_W, 32, stall-counter width

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous active-high reset
- dec_valid  in  1  decode slot holds a real instruction
- dec_rd_sel  in  REG_AW  decode destination register
- dec_rd_we  in  1  decode instruction writes rd
- dec_is_load  in  1  decode instruction is a load
- dec_rs1_sel / dec_rs2_sel  in  REG_AW  decode source registers
- dec_rs1_used / dec_rs2_used  in  1  source actually read
- flush  in  1  taken branch/jump: kill the instruction entering EX
- pipe_hold  in  1  memory wait: freeze all stage registers
- ex_alu_val  in  XLEN  EX-stage ALU result
- mem_alu_val  in  XLEN  MEM-stage ALU result
- mem_load_val  in  XLEN  MEM-stage load data
- wb_val  in  XLEN  WB-stage write data
- EX_raw_sel / MEM_raw_sel / WB_raw_sel  out  REG_AW  stage destination tags
- EX_raw_val / MEM_raw_val / WB_raw_val  out  XLEN  stage forwarding values
- dec_stall  out  1  hold PC and IF/ID this cycle
- stall_cnt  out  CNT_W  saturating count of load-use stall cycles

Behaviour:
- Tag entry per stage: {valid, rd, is_load}. Stage is "live" when valid & rd_we & rd!=0. Only live stages are stored as valid.
- Reset: all entries invalid, stall_cnt=0. All sel/val outputs are 0, dec_stall=0.
- Output masking (combinational from registered tags):
  - Non-live stage drives sel=0 and val=0, so x0 reads through the forwarding mux return 0.
  - EX live non-load: EX_raw_sel=rd, EX_raw_val=ex_alu_val.
  - EX live load: EX_raw_sel=rd, EX_raw_val=0. Data is not yet available; dec_stall covers this case.
  - MEM live: val = is_load ? mem_load_val : mem_alu_val.
  - WB live: val = wb_val.
- Load-use detect (combinational):
  - dec_stall = dec_valid & EX live load & ((dec_rs1_used & rs1==EX rd) | (dec_rs2_used & rs2==EX rd)) & !flush.
  - Never stalls on x0.
- Advance on each clk when pipe_hold=0:
  - MEM<=EX, WB<=MEM.
  - EX<=decode tag, unless dec_stall or flush, in which case EX<=bubble (invalid).
  - Decode tag with dec_valid=0 also enters EX as a bubble.
- pipe_hold=1: all three entries and stall_cnt hold. dec_stall output still evaluated but is not counted.
- flush and dec_stall together: flush wins, bubble inserted, dec_stall=0.
- Latency: a tag is visible on EX outputs 1 cycle after its decode cycle, on MEM after 2, on WB after 3.
- A load followed directly by a dependent instruction costs exactly 1 stall cycle. The consumer then takes its value via MEM_raw_val.
- stall_cnt increments by 1 per cycle with dec_stall=1 & pipe_hold=0, and saturates at all-ones.
- Reset mid-operation: all entries cleared on the next edge. No stall outputs appear in that cycle's outputs after the edge.

Decomposition:
- Shared package (e.g. rv_pipe_pkg): tag struct {valid, rd[REG_AW-1:0], is_load}, REG_AW, XLEN, X0 constant.
- One natural sub-module: fwd_tag_stage, a single hold-able tag register with a bubble-insert input, instantiated three times.
- Masking, hazard detect and counter stay in the top level.

Test Plan:
- `addi x5` decoded at cycle 0, with ex_alu_val=0x11, mem_alu_val=0x11, wb_val=0x11 driven in the matching cycles -> EX_raw_sel=5/val=0x11 at cycle 1, MEM at cycle 2, WB at cycle 3; all other sel=0.
- `lw x7` then `add x8,x7,x1` with mem_load_val=0xDEAD -> dec_stall=1 for exactly one cycle, EX bubble (EX_raw_sel=0), next cycle MEM_raw_sel=7/val=0xDEAD, stall_cnt=1.
- `lw x0` followed by an instruction using rs1=x0 -> dec_stall=0, all sel=0, stall_cnt=0.
- `lw x9` then consumer with flush=1 in the same cycle -> dec_stall=0, EX bubble inserted, stall_cnt unchanged.
- Tags in all stages, then pipe_hold=1 for 3 cycles -> sel/val tags frozen and stall_cnt frozen; release resumes the shift.
- Pipeline full and rst=1 for one cycle -> next cycle all sel/val=0, dec_stall=0, stall_cnt=0.
